// File: rtl/fbox_cvt_resp_buffer.sv
// Result staging FIFO behind the fbox int-to-float converter.
// NaN-boxes single results on push and accrues committed exception flags for fcsr.
module fbox_cvt_resp_buffer #(
  parameter int unsigned FLEN  = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FLEN-1:0] in_result,
  input  logic            in_single,
  input  logic [4:0]      in_flags,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FLEN-1:0] out_result,
  output logic [4:0]      out_flags,
  output logic [TAGW-1:0] out_tag,
  input  logic            fflags_clear,
  output logic [4:0]      fflags_acc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [FLEN-1:0] resultQ [DEPTH];
  logic [4:0]      flagsQ  [DEPTH];
  logic [TAGW-1:0] tagQ    [DEPTH];

  logic [PtrW-1:0] rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
  logic [CntW-1:0] countQ, countD;
  logic [4:0]      accQ, accD;
  logic [FLEN-1:0] boxedResult;
  logic            push, pop;

  // Handshakes depend on registered count only, so in_ready never sees out_ready.
  assign in_ready  = (countQ != CntW'(DEPTH));
  assign out_valid = (countQ != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result = resultQ[rdPtrQ];
  assign out_flags  = flagsQ[rdPtrQ];
  assign out_tag    = tagQ[rdPtrQ];
  assign fflags_acc = accQ;

  always_comb begin
    boxedResult = in_result;
    if (in_single) begin
      boxedResult = {{(FLEN-32){1'b1}}, in_result[31:0]};
    end
  end

  // DEPTH is a power of two, so pointer overflow wraps naturally.
  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    accD   = fflags_clear ? 5'b0 : accQ;
    if (push) begin
      wrPtrD = wrPtrQ + PtrW'(1);
    end
    if (pop) begin
      rdPtrD = rdPtrQ + PtrW'(1);
      accD   = accD | flagsQ[rdPtrQ];
    end
    if (push && !pop) begin
      countD = countQ + CntW'(1);
    end else if (pop && !push) begin
      countD = countQ - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
      accQ   <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
      accQ   <= accD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        resultQ[i] <= '0;
        flagsQ[i]  <= '0;
        tagQ[i]    <= '0;
      end
    end else if (push) begin
      resultQ[wrPtrQ] <= boxedResult;
      flagsQ[wrPtrQ]  <= in_flags;
      tagQ[wrPtrQ]    <= in_tag;
    end
  end

endmodule

// File: tb/tb_fbox_cvt_resp_buffer.sv
// Directed bench for fbox_cvt_resp_buffer at FLEN=64, DEPTH=2, TAGW=5.
module tb_fbox_cvt_resp_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_single;
  logic [63:0] in_result;
  logic [4:0]  in_flags;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_flags;
  logic [4:0]  out_tag;
  logic        fflags_clear;
  logic [4:0]  fflags_acc;

  int total = 0;
  int fails = 0;

  fbox_cvt_resp_buffer #(
    .FLEN (64),
    .DEPTH(2),
    .TAGW (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_single   (in_single),
    .in_flags    (in_flags),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .out_tag     (out_tag),
    .fflags_clear(fflags_clear),
    .fflags_acc  (fflags_acc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input logic s, input logic [4:0] f,
                       input logic [4:0] t);
    in_valid  = v;
    in_result = r;
    in_single = s;
    in_flags  = f;
    in_tag    = t;
  endtask

  initial begin
    rst_n        = 1'b0;
    out_ready    = 1'b0;
    fflags_clear = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 5'b0, 5'd0);
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_fflags_acc", fflags_acc, 0);
    #9 rst_n = 1'b1;
    tick();

    // Single double push, popped immediately.
    out_ready = 1'b1;
    drive(1'b1, 64'h4000_0000_0000_0000, 1'b0, 5'b0, 5'd3);
    chk("t1_not_yet_valid", out_valid, 0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'b0, 5'd0);
    chk("t1_valid", out_valid, 1);
    chk("t1_result", out_result, 64'h4000_0000_0000_0000);
    chk("t1_tag", out_tag, 3);
    tick();
    chk("t1_one_cycle", out_valid, 0);
    chk("t1_acc", fflags_acc, 0);

    // NaN-boxing of a single result.
    out_ready = 1'b0;
    drive(1'b1, 64'h1234_5678_3F80_0000, 1'b1, 5'b0, 5'd7);
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'b0, 5'd0);
    chk("t2_boxed", out_result, 64'hFFFF_FFFF_3F80_0000);
    chk("t2_tag", out_tag, 7);
    out_ready = 1'b1;
    tick();
    chk("t2_drained", out_valid, 0);

    // Fill with out_ready low, third push must stall.
    out_ready = 1'b0;
    drive(1'b1, 64'h11, 1'b0, 5'b0, 5'd1);
    tick();
    chk("t3_ready_after1", in_ready, 1);
    drive(1'b1, 64'h22, 1'b0, 5'b0, 5'd2);
    tick();
    chk("t3_full", in_ready, 0);
    chk("t3_head1", out_tag, 1);
    drive(1'b1, 64'h33, 1'b0, 5'b0, 5'd3);
    tick();
    chk("t3_still_full", in_ready, 0);
    chk("t3_head_held", out_tag, 1);
    out_ready = 1'b1;
    tick();
    chk("t3_head2", out_tag, 2);
    chk("t3_result2", out_result, 64'h22);
    chk("t3_ready_again", in_ready, 1);
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'b0, 5'd0);
    chk("t3_head3", out_tag, 3);
    chk("t3_result3", out_result, 64'h33);
    chk("t3_valid3", out_valid, 1);
    tick();
    chk("t3_empty", out_valid, 0);

    // Flags accrue on pop, not on push.
    out_ready = 1'b0;
    drive(1'b1, 64'h1, 1'b0, 5'b00001, 5'd4);
    tick();
    drive(1'b1, 64'h2, 1'b0, 5'b00100, 5'd5);
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'b0, 5'd0);
    chk("t4_no_acc_on_push", fflags_acc, 0);
    out_ready = 1'b1;
    tick();
    chk("t4_acc1", fflags_acc, 5'b00001);
    tick();
    chk("t4_acc2", fflags_acc, 5'b00101);
    out_ready = 1'b0;
    drive(1'b1, 64'h3, 1'b0, 5'b10000, 5'd6);
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'b0, 5'd0);
    out_ready    = 1'b1;
    fflags_clear = 1'b1;
    tick();
    chk("t4_clear_with_pop", fflags_acc, 5'b10000);
    chk("t4_empty", out_valid, 0);
    tick();
    chk("t4_clear_only", fflags_acc, 0);
    fflags_clear = 1'b0;

    // Streaming: one result per cycle through wrapping pointers.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'hA000 + 64'(i), 1'b0, 5'b00001, 5'(8 + i));
      tick();
      chk("t5_valid", out_valid, 1);
      chk("t5_tag", out_tag, 64'(8 + i));
      chk("t5_result", out_result, 64'hA000 + 64'(i));
      chk("t5_in_ready", in_ready, 1);
    end
    drive(1'b0, 64'h0, 1'b0, 5'b0, 5'd0);
    tick();
    chk("t5_drained", out_valid, 0);
    chk("t5_acc", fflags_acc, 5'b00001);

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    drive(1'b1, 64'h55, 1'b0, 5'b00010, 5'd20);
    tick();
    drive(1'b1, 64'h66, 1'b0, 5'b00010, 5'd21);
    tick();
    drive(1'b0, 64'h0, 1'b0, 5'b0, 5'd0);
    chk("t6_full_before", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_acc", fflags_acc, 0);
    chk("t6_rst_result", out_result, 0);
    out_ready = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    chk("t6_no_commit_valid", out_valid, 0);
    tick();
    chk("t6_no_commit_acc", fflags_acc, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/fbox_cvt_resp_buffer.md
Name: fbox_cvt_resp_buffer

Overview:
- Result staging stage directly downstream of the int-to-float converter in the fbox.
- Captures the converted IEEE result, its 5-bit exception flags and destination tag; NaN-boxes single-precision results to FLEN.
- Buffers results in a small FIFO with valid/ready handshakes toward writeback.
- Maintains the sticky accrued-fflags value that feeds fcsr.

Parameters:
- FLEN, 64, width of the FP register file / output result.
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- TAGW, 5, destination register tag width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  converter result valid.
- in_ready  output  1  buffer can accept a result this cycle.
- in_result  input  FLEN  raw converter output; single-precision results occupy bits [31:0].
- in_single  input  1  1 = single-precision result, 0 = double.
- in_flags  input  5  exception flags {NV,DZ,OF,UF,NX}.
- in_tag  input  TAGW  destination register tag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback accepts the head entry.
- out_result  output  FLEN  head result, already NaN-boxed.
- out_flags  output  5  head entry flags.
- out_tag  output  TAGW  head entry tag.
- fflags_clear  input  1  clears the accrued flags (fcsr write).
- fflags_acc  output  5  sticky OR of committed flags.

Behaviour:
- Reset (asynchronous, rst_n=0): count=0, rd_ptr=0, wr_ptr=0, fflags_acc=0, all storage zero. Outputs: out_valid=0, in_ready=1, out_result=0, out_flags=0, out_tag=0. Reset mid-operation discards all entries; no partial commit.
- Push: in_valid & in_ready at a rising edge. The entry is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
- NaN-boxing is applied at push:
  - in_single=1: stored result = {(FLEN-32) ones, in_result[31:0]}.
  - in_single=0: stored result = in_result unchanged.
- Pop: out_valid & out_ready at a rising edge. rd_ptr increments, wrapping modulo DEPTH.
- Output data: out_result, out_flags and out_tag always show the entry at rd_ptr.
- Latency: no bypass. A pushed entry appears on out_valid in the cycle after the push; minimum 1 cycle.
- in_ready = (count != DEPTH), driven from registered state only, with no combinational path from out_ready.
  - When full, push is refused even if a pop happens the same cycle.
- out_valid = (count != 0).
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together (count between 1 and DEPTH-1): count unchanged.
  - Push when empty: cannot pop in the same cycle.
- Full throughput: sustained 1 result/cycle when out_ready is held high.
- Accrued flags are updated on pop (commit), not on push:
  - fflags_acc_next = (fflags_clear ? 0 : fflags_acc) | (pop ? head flags : 0).
  - When fflags_clear and a pop coincide, the popped flags survive the clear.
- in_valid while in_ready=0 has no effect. The upstream must hold the result until accepted.
- Storage, pointer and count widths: pointers are log2(DEPTH) bits; count is log2(DEPTH)+1 bits.

Test Plan:
- Reset, then one push of a double 0x4000_0000_0000_0000 with flags 0, tag 3 and out_ready=1 -> out_valid high for exactly one cycle, 1 cycle after the push, with out_result 0x4000000000000000 and out_tag 3; fflags_acc stays 0.
- Single push with in_result[31:0]=0x3F80_0000 and in_single=1 -> out_result=0xFFFFFFFF_3F800000.
- out_ready=0 with 3 back-to-back pushes at DEPTH=2 -> first two accepted; in_ready low after the 2nd; the 3rd is held until the first pop. Order is preserved as tags 1, 2, 3.
- Push flags 5'b00001, then 5'b00100, with both popped -> fflags_acc=5'b00101. Then assert fflags_clear in the same cycle as a pop with flags 5'b10000 -> fflags_acc=5'b10000.
- Continuous push/pop for 8 cycles with out_ready=1 -> 8 results in order, no bubbles after the first, pointers wrap correctly.
- Assert rst_n=0 with 2 entries held -> out_valid=0, in_ready=1 and fflags_acc=0 immediately (asynchronous), and no entry is committed afterwards.
